// File: rtl/mvau_weight_seq.sv
// Weight-memory sequencer for the batch MVAU: walks the weight address through all
// synapse/neuron folds, fills the input buffer on the first fold and replays it afterwards.
module mvau_weight_seq #(
  parameter int MATRIXW      = 4,
  parameter int MATRIXH      = 4,
  parameter int SIMD         = 2,
  parameter int PE           = 2,
  parameter int SF           = MATRIXW / SIMD,
  parameter int NF           = MATRIXH / PE,
  parameter int WMEM_DEPTH   = SF * NF,
  parameter int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
  parameter int SF_BW        = (SF > 1) ? $clog2(SF) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    in_v,
  output logic                    in_rdy,
  input  logic                    out_rdy,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    buf_wr_en,
  output logic [SF_BW-1:0]        buf_addr,
  output logic                    buf_rd_sel,
  output logic                    ce,
  output logic                    dp_v,
  output logic                    dp_sf_last,
  output logic                    dp_nf_last
);

  localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [SF_BW-1:0]        SF_MAX   = SF_BW'(SF - 1);
  localparam logic [NF_BW-1:0]        NF_MAX   = NF_BW'(NF - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_MAX = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_REUSE = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SF_BW-1:0]        sf_cnt_r, sf_nxt_s;
  logic [NF_BW-1:0]        nf_cnt_r, nf_nxt_s;
  logic [WMEM_ADDR_BW-1:0] wmem_addr_r, addr_nxt_s, addr_inc_s;
  logic                    reuse_s, ce_s, sf_last_s, nf_last_s;
  logic                    dp_v_r, dp_sf_last_r, dp_nf_last_r;

  // Decode the operand source from the FSM state
  always_comb begin
    reuse_s = 1'b0;
    case (state_r)
      ST_FILL:  reuse_s = 1'b0;
      ST_REUSE: reuse_s = 1'b1;
      default:  reuse_s = 1'b0;
    endcase
  end

  assign ce_s       = out_rdy && (reuse_s || in_v);
  assign sf_last_s  = (sf_cnt_r == SF_MAX);
  assign nf_last_s  = (nf_cnt_r == NF_MAX);
  assign addr_inc_s = (wmem_addr_r == ADDR_MAX) ? {WMEM_ADDR_BW{1'b0}}
                                                : wmem_addr_r + WMEM_ADDR_BW'(1);

  // Next-state and counter stepping; nothing moves without a step issue
  always_comb begin
    state_nxt_s = state_r;
    sf_nxt_s    = sf_cnt_r;
    nf_nxt_s    = nf_cnt_r;
    addr_nxt_s  = wmem_addr_r;
    if (ce_s) begin
      if (!sf_last_s) begin
        sf_nxt_s   = sf_cnt_r + SF_BW'(1);
        addr_nxt_s = addr_inc_s;
      end else if (!nf_last_s) begin
        sf_nxt_s    = {SF_BW{1'b0}};
        nf_nxt_s    = nf_cnt_r + NF_BW'(1);
        addr_nxt_s  = addr_inc_s;
        state_nxt_s = ST_REUSE;
      end else begin
        // last step of the vector: rewind everything for the next one
        sf_nxt_s    = {SF_BW{1'b0}};
        nf_nxt_s    = {NF_BW{1'b0}};
        addr_nxt_s  = {WMEM_ADDR_BW{1'b0}};
        state_nxt_s = ST_FILL;
      end
    end else begin
      state_nxt_s = state_r;
      sf_nxt_s    = sf_cnt_r;
      nf_nxt_s    = nf_cnt_r;
      addr_nxt_s  = wmem_addr_r;
    end
  end

  // FSM state, fold counters and weight address registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_FILL;
      sf_cnt_r    <= {SF_BW{1'b0}};
      nf_cnt_r    <= {NF_BW{1'b0}};
      wmem_addr_r <= {WMEM_ADDR_BW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sf_cnt_r    <= sf_nxt_s;
      nf_cnt_r    <= nf_nxt_s;
      wmem_addr_r <= addr_nxt_s;
    end
  end

  // Datapath strobes delayed one cycle to line up with the synchronous weight read
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dp_v_r       <= 1'b0;
      dp_sf_last_r <= 1'b0;
      dp_nf_last_r <= 1'b0;
    end else begin
      dp_v_r       <= ce_s;
      dp_sf_last_r <= ce_s && sf_last_s;
      dp_nf_last_r <= ce_s && sf_last_s && nf_last_s;
    end
  end

  assign in_rdy     = out_rdy && !reuse_s;
  assign buf_wr_en  = ce_s && !reuse_s;
  assign buf_addr   = sf_cnt_r;
  assign buf_rd_sel = reuse_s;
  assign ce         = ce_s;
  assign wmem_addr  = wmem_addr_r;
  assign dp_v       = dp_v_r;
  assign dp_sf_last = dp_sf_last_r;
  assign dp_nf_last = dp_nf_last_r;

endmodule

// File: tb/tb_mvau_weight_seq.sv
// Directed self-checking bench for mvau_weight_seq: a 2x3-fold instance plus an NF=1 instance.
module tb_mvau_weight_seq;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       in_v = 1'b0, out_rdy = 1'b0;
  logic       in_rdy, buf_wr_en, buf_rd_sel, ce, dp_v, dp_sf_last, dp_nf_last;
  logic [2:0] wmem_addr;
  logic [0:0] buf_addr;

  logic       in_v1 = 1'b0, out_rdy1 = 1'b0;
  logic       in_rdy1, buf_wr_en1, buf_rd_sel1, ce1, dp_v1, dp_sf_last1, dp_nf_last1;
  logic [0:0] wmem_addr1, buf_addr1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  mvau_weight_seq #(.MATRIXW(4), .MATRIXH(6), .SIMD(2), .PE(2)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .in_v(in_v), .in_rdy(in_rdy), .out_rdy(out_rdy),
    .wmem_addr(wmem_addr), .buf_wr_en(buf_wr_en), .buf_addr(buf_addr),
    .buf_rd_sel(buf_rd_sel), .ce(ce), .dp_v(dp_v), .dp_sf_last(dp_sf_last),
    .dp_nf_last(dp_nf_last)
  );

  mvau_weight_seq #(.MATRIXW(4), .MATRIXH(2), .SIMD(2), .PE(2)) u_dut_nf1 (
    .aclk(aclk), .aresetn(aresetn), .in_v(in_v1), .in_rdy(in_rdy1), .out_rdy(out_rdy1),
    .wmem_addr(wmem_addr1), .buf_wr_en(buf_wr_en1), .buf_addr(buf_addr1),
    .buf_rd_sel(buf_rd_sel1), .ce(ce1), .dp_v(dp_v1), .dp_sf_last(dp_sf_last1),
    .dp_nf_last(dp_nf_last1)
  );

  // Hand-computed expectation tables; bit/element c belongs to cycle c of the scenario
  localparam int         S1_ADDR [8]  = '{0, 1, 2, 3, 4, 5, 0, 1};
  localparam logic [7:0] S1_INRDY     = 8'b1100_0011;
  localparam logic [7:0] S1_BADDR     = 8'b1010_1010;
  localparam logic [7:0] S1_RDSEL     = 8'b0011_1100;
  localparam logic [7:0] S1_DPV       = 8'b1111_1110;
  localparam logic [7:0] S1_SFL       = 8'b0101_0100;
  localparam logic [7:0] S1_NFL       = 8'b0100_0000;

  localparam logic [9:0] S2_INV       = 10'b00_0011_0001;
  localparam int         S2_ADDR [10] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 0};
  localparam logic [9:0] S2_CE        = 10'b01_1111_0001;
  localparam logic [9:0] S2_DPV       = 10'b11_1110_0010;
  localparam logic [9:0] S2_RDSEL     = 10'b01_1110_0000;

  localparam logic [7:0] S3_ORDY      = 8'b0111_0111;
  localparam int         S3_ADDR [8]  = '{0, 1, 2, 3, 3, 4, 5, 0};
  localparam logic [7:0] S3_DPV       = 8'b1110_1110;
  localparam logic [7:0] S3_INRDY     = 8'b0000_0011;
  localparam logic [7:0] S3_SFL       = 8'b1010_0100;
  localparam logic [7:0] S3_NFL       = 8'b1000_0000;

  localparam int         S5_ADDR [6]  = '{0, 1, 0, 1, 0, 1};
  localparam logic [5:0] S5_DPV       = 6'b11_1110;
  localparam logic [5:0] S5_LAST      = 6'b01_0100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    in_v     = 1'b0;
    out_rdy  = 1'b0;
    in_v1    = 1'b0;
    out_rdy1 = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int k, cyc, n_dpv, n_sfl, n_nfl;
    logic iv, ordy, exp_ce;

    // Reset values, with out_rdy high to see in_rdy follow it
    aresetn = 1'b0;
    out_rdy = 1'b1;
    #3;
    check("rst_addr", 32'(wmem_addr), 32'd0);
    check("rst_dpv", 32'(dp_v), 32'd0);
    check("rst_sfl", 32'(dp_sf_last), 32'd0);
    check("rst_nfl", 32'(dp_nf_last), 32'd0);
    check("rst_inrdy", 32'(in_rdy), 32'd1);
    check("rst_wren", 32'(buf_wr_en), 32'd0);
    check("rst_baddr", 32'(buf_addr), 32'd0);
    check("rst_rdsel", 32'(buf_rd_sel), 32'd0);
    do_reset();

    // Scenario 1: streaming at full rate
    for (int c = 0; c < 8; c++) begin
      in_v = 1'b1;
      out_rdy = 1'b1;
      @(negedge aclk);
      check($sformatf("s1_addr_c%0d", c), 32'(wmem_addr), 32'(S1_ADDR[c]));
      check($sformatf("s1_inrdy_c%0d", c), 32'(in_rdy), 32'(S1_INRDY[c]));
      check($sformatf("s1_wren_c%0d", c), 32'(buf_wr_en), 32'(S1_INRDY[c]));
      check($sformatf("s1_baddr_c%0d", c), 32'(buf_addr), 32'(S1_BADDR[c]));
      check($sformatf("s1_rdsel_c%0d", c), 32'(buf_rd_sel), 32'(S1_RDSEL[c]));
      check($sformatf("s1_ce_c%0d", c), 32'(ce), 32'd1);
      check($sformatf("s1_dpv_c%0d", c), 32'(dp_v), 32'(S1_DPV[c]));
      check($sformatf("s1_sfl_c%0d", c), 32'(dp_sf_last), 32'(S1_SFL[c]));
      check($sformatf("s1_nfl_c%0d", c), 32'(dp_nf_last), 32'(S1_NFL[c]));
      next_cycle();
    end
    do_reset();

    // Scenario 2: input starvation in FILL, none in REUSE
    for (int c = 0; c < 10; c++) begin
      in_v = S2_INV[c];
      out_rdy = 1'b1;
      @(negedge aclk);
      check($sformatf("s2_addr_c%0d", c), 32'(wmem_addr), 32'(S2_ADDR[c]));
      check($sformatf("s2_ce_c%0d", c), 32'(ce), 32'(S2_CE[c]));
      check($sformatf("s2_dpv_c%0d", c), 32'(dp_v), 32'(S2_DPV[c]));
      check($sformatf("s2_rdsel_c%0d", c), 32'(buf_rd_sel), 32'(S2_RDSEL[c]));
      next_cycle();
    end
    do_reset();

    // Scenario 3: one backpressure cycle at address 3
    for (int c = 0; c < 8; c++) begin
      in_v = 1'b1;
      out_rdy = S3_ORDY[c];
      @(negedge aclk);
      check($sformatf("s3_addr_c%0d", c), 32'(wmem_addr), 32'(S3_ADDR[c]));
      check($sformatf("s3_ce_c%0d", c), 32'(ce), 32'(S3_ORDY[c]));
      check($sformatf("s3_dpv_c%0d", c), 32'(dp_v), 32'(S3_DPV[c]));
      check($sformatf("s3_inrdy_c%0d", c), 32'(in_rdy), 32'(S3_INRDY[c]));
      check($sformatf("s3_sfl_c%0d", c), 32'(dp_sf_last), 32'(S3_SFL[c]));
      check($sformatf("s3_nfl_c%0d", c), 32'(dp_nf_last), 32'(S3_NFL[c]));
      next_cycle();
    end
    do_reset();

    // Scenario 4: asynchronous reset in the middle of cycle 4 (address 4, REUSE)
    for (int c = 0; c < 4; c++) begin
      in_v = 1'b1;
      out_rdy = 1'b1;
      @(negedge aclk);
      check($sformatf("s4_addr_c%0d", c), 32'(wmem_addr), 32'(c));
      next_cycle();
    end
    #2;
    check("s4_pre_addr", 32'(wmem_addr), 32'd4);
    check("s4_pre_dpv", 32'(dp_v), 32'd1);
    check("s4_pre_rdsel", 32'(buf_rd_sel), 32'd1);
    aresetn = 1'b0;
    #1;
    check("s4_rst_dpv", 32'(dp_v), 32'd0);
    check("s4_rst_addr", 32'(wmem_addr), 32'd0);
    check("s4_rst_rdsel", 32'(buf_rd_sel), 32'd0);
    check("s4_rst_inrdy", 32'(in_rdy), 32'd1);
    in_v = 1'b0;
    next_cycle();
    aresetn = 1'b1;
    #1;
    in_v = 1'b1;
    @(negedge aclk);
    check("s4_post_wren", 32'(buf_wr_en), 32'd1);
    check("s4_post_baddr", 32'(buf_addr), 32'd0);
    check("s4_post_addr", 32'(wmem_addr), 32'd0);
    check("s4_post_dpv", 32'(dp_v), 32'd0);
    next_cycle();
    @(negedge aclk);
    check("s4_post2_addr", 32'(wmem_addr), 32'd1);
    check("s4_post2_dpv", 32'(dp_v), 32'd1);
    next_cycle();
    do_reset();

    // Scenario 5: NF=1 instance never leaves FILL
    for (int c = 0; c < 6; c++) begin
      in_v1 = 1'b1;
      out_rdy1 = 1'b1;
      @(negedge aclk);
      check($sformatf("s5_addr_c%0d", c), 32'(wmem_addr1), 32'(S5_ADDR[c]));
      check($sformatf("s5_rdsel_c%0d", c), 32'(buf_rd_sel1), 32'd0);
      check($sformatf("s5_dpv_c%0d", c), 32'(dp_v1), 32'(S5_DPV[c]));
      check($sformatf("s5_sfl_c%0d", c), 32'(dp_sf_last1), 32'(S5_LAST[c]));
      check($sformatf("s5_nfl_c%0d", c), 32'(dp_nf_last1), 32'(S5_LAST[c]));
      next_cycle();
    end
    do_reset();

    // Scenario 6: three vectors with random gaps against a step-count model
    k = 0;
    cyc = 0;
    n_dpv = 0;
    n_sfl = 0;
    n_nfl = 0;
    while (k < 18 && cyc < 400) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      in_v = iv;
      out_rdy = ordy;
      exp_ce = ordy && (((k % 6) >= 2) || iv);
      @(negedge aclk);
      check($sformatf("s6_ce_c%0d", cyc), 32'(ce), 32'(exp_ce));
      check($sformatf("s6_addr_c%0d", cyc), 32'(wmem_addr), 32'(k % 6));
      if (iv && in_rdy) begin
        check($sformatf("s6_acc_addr_c%0d", cyc), 32'(wmem_addr < 3'd2), 32'd1);
      end
      n_dpv += int'(dp_v);
      n_sfl += int'(dp_sf_last);
      n_nfl += int'(dp_nf_last);
      if (exp_ce) begin
        k++;
      end
      cyc++;
      next_cycle();
    end
    check("s6_steps_issued", 32'(k), 32'd18);
    in_v = 1'b0;
    out_rdy = 1'b0;
    @(negedge aclk);
    n_dpv += int'(dp_v);
    n_sfl += int'(dp_sf_last);
    n_nfl += int'(dp_nf_last);
    check("s6_dpv_count", 32'(n_dpv), 32'd18);
    check("s6_sfl_count", 32'(n_sfl), 32'd9);
    check("s6_nfl_count", 32'(n_nfl), 32'd3);
    check("s6_end_addr", 32'(wmem_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
